dsp_tapline: RTL and testbench

//   Parametrised tap delay line for the DSP datapath: shifts WIDTH-bit samples into
//   a DEPTH-word register. Reads out one tap on request, or bursts out all taps.

---
 rtl/dsp_tapline_pkg.sv | 23 ++
 rtl/dsp_tapline_if.sv | 29 ++
 rtl/dsp_tapline_tap_mux.sv | 24 ++
 rtl/dsp_tapline.sv | 130 +++++++++++++
 tb/tb_dsp_tapline.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/dsp_tapline_pkg.sv
// Shared types and helpers for the tap delay line.
package dsp_tapline_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Number of bits needed to hold values 0..v-1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned p;
        r = 0;
        p = 1;
        while (p < v) begin
            p = p << 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dsp_tapline_if.sv
// Request/response bundle between the sample source and the tap delay line.
interface dsp_tapline_if #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned TAP_W = 3
);
    logic             en;
    logic             we;
    logic [WIDTH-1:0] din;
    logic             rd;
    logic [TAP_W-1:0] tap;
    logic             start;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             err;
    logic             busy;
    logic             done;
    logic             lost;
    logic [TAP_W:0]   fill;

    modport master (
        output en, we, din, rd, tap, start,
        input  dout, dout_valid, err, busy, done, lost, fill
    );

    modport slave (
        input  en, we, din, rd, tap, start,
        output dout, dout_valid, err, busy, done, lost, fill
    );
endinterface

// File: rtl/dsp_tapline_tap_mux.sv
// DEPTH:1 tap selector with an in-range flag for indices beyond the last tap.
module dsp_tapline_tap_mux #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned TAP_W = 3
) (
    input  logic [WIDTH-1:0] taps [DEPTH],
    input  logic [TAP_W-1:0] sel,
    output logic [WIDTH-1:0] data_c,
    output logic             in_range_c
);

    always_comb begin
        data_c     = '0;
        in_range_c = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (sel == TAP_W'(i)) begin
                data_c     = taps[i];
                in_range_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dsp_tapline.sv
// Tap delay line: shift register with single-tap reads, burst readout,
// fill tracking and lost-write detection.
module dsp_tapline
    import dsp_tapline_pkg::*;
#(
    parameter int unsigned     WIDTH   = 24,
    parameter int unsigned     DEPTH   = 8,
    parameter int unsigned     TAP_W   = 3,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rstn,
    dsp_tapline_if.slave  bus
);

    localparam int unsigned CNT_W  = clog2(DEPTH + 1);
    localparam int unsigned FILL_W = TAP_W + 1;

    logic [WIDTH-1:0] sr [DEPTH];
    state_t           state;
    logic [CNT_W-1:0] idx;
    logic [TAP_W-1:0] sel_c;
    logic [WIDTH-1:0] mux_data_c;
    logic             mux_in_range_c;
    logic             shift_c;

    assign shift_c = bus.en && bus.we && (state == ST_IDLE);

    // Burst reads follow idx; an accepted start prefetches tap 0.
    always_comb begin
        if (state == ST_BURST) begin
            sel_c = TAP_W'(idx);
        end else if (bus.start) begin
            sel_c = '0;
        end else begin
            sel_c = bus.tap;
        end
    end

    dsp_tapline_tap_mux #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .TAP_W (TAP_W)
    ) u_mux (
        .taps       (sr),
        .sel        (sel_c),
        .data_c     (mux_data_c),
        .in_range_c (mux_in_range_c)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                sr[i] <= RST_VAL;
            end
        end else if (shift_c) begin
            sr[0] <= bus.din;
            for (int i = 1; i < int'(DEPTH); i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    // Output registers lead the FSM by one word so busy and dout_valid align.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state          <= ST_IDLE;
            idx            <= '0;
            bus.dout       <= '0;
            bus.dout_valid <= 1'b0;
            bus.err        <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.lost       <= 1'b0;
            bus.fill       <= '0;
        end else if (!bus.en) begin
            bus.dout_valid <= 1'b0;
            bus.done       <= 1'b0;
            bus.err        <= 1'b0;
        end else begin
            bus.dout_valid <= 1'b0;
            bus.done       <= 1'b0;
            bus.err        <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.we && (bus.fill != FILL_W'(DEPTH))) begin
                        bus.fill <= bus.fill + 1'b1;
                    end
                    if (bus.start) begin
                        state          <= ST_BURST;
                        idx            <= CNT_W'(1);
                        bus.busy       <= 1'b1;
                        bus.lost       <= 1'b0;
                        bus.dout       <= bus.we ? bus.din : mux_data_c;
                        bus.dout_valid <= 1'b1;
                    end else if (bus.rd) begin
                        bus.dout       <= mux_in_range_c ? mux_data_c : '0;
                        bus.err        <= !mux_in_range_c;
                        bus.dout_valid <= 1'b1;
                    end
                end
                ST_BURST: begin
                    if (bus.we) begin
                        bus.lost <= 1'b1;
                    end
                    if (idx == CNT_W'(DEPTH)) begin
                        state    <= ST_DONE;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                    end else begin
                        bus.dout       <= mux_data_c;
                        bus.dout_valid <= 1'b1;
                        idx            <= idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (bus.we) begin
                        bus.lost <= 1'b1;
                    end
                    state <= ST_IDLE;
                end
                default: begin
                    state    <= ST_IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dsp_tapline.sv
// Directed checks of the tap delay line (DEPTH=8, TAP_W=4, non-zero reset value).
module tb_dsp_tapline;

    localparam int unsigned     WIDTH = 24;
    localparam int unsigned     DEPTH = 8;
    localparam int unsigned     TAP_W = 4;
    localparam logic [23:0]     RV    = 24'h5A5A5A;

    logic clk;
    logic rstn;
    int   n_chk;
    int   n_fail;

    dsp_tapline_if #(.WIDTH(WIDTH), .TAP_W(TAP_W)) bus ();

    dsp_tapline #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .TAP_W   (TAP_W),
        .RST_VAL (RV)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        assert (obs === exp) else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        rstn      = 1'b0;
        bus.en    = 1'b0;
        bus.we    = 1'b0;
        bus.din   = '0;
        bus.rd    = 1'b0;
        bus.tap   = '0;
        bus.start = 1'b0;
        cyc();
        cyc();

        chk("rst_dout",  32'(bus.dout), 32'h0);
        chk("rst_valid", 32'(bus.dout_valid), 32'h0);
        chk("rst_busy",  32'(bus.busy), 32'h0);
        chk("rst_done",  32'(bus.done), 32'h0);
        chk("rst_lost",  32'(bus.lost), 32'h0);
        chk("rst_err",   32'(bus.err), 32'h0);
        chk("rst_fill",  32'(bus.fill), 32'h0);

        rstn   = 1'b1;
        bus.en = 1'b1;
        cyc();
        bus.rd  = 1'b1;
        bus.tap = 4'd3;
        cyc();
        bus.rd = 1'b0;
        chk("rd_rstval", 32'(bus.dout), 32'(RV));
        chk("rd_rstval_v", 32'(bus.dout_valid), 32'h1);

        for (int v = 1; v <= 8; v++) begin
            bus.we  = 1'b1;
            bus.din = 24'(v);
            cyc();
            chk("fill_inc", 32'(bus.fill), 32'(v));
        end
        bus.we = 1'b0;

        bus.rd  = 1'b1;
        bus.tap = 4'd0;
        cyc();
        chk("rd_tap0", 32'(bus.dout), 32'h8);
        chk("rd_tap0_err", 32'(bus.err), 32'h0);
        bus.tap = 4'd7;
        cyc();
        chk("rd_tap7", 32'(bus.dout), 32'h1);

        // Read and write together: read sees pre-write contents.
        bus.tap = 4'd0;
        bus.we  = 1'b1;
        bus.din = 24'h000009;
        cyc();
        bus.we = 1'b0;
        chk("rd_prewrite", 32'(bus.dout), 32'h8);
        chk("fill_sat", 32'(bus.fill), 32'h8);
        bus.tap = 4'd7;
        cyc();
        chk("rd_tap7_shift", 32'(bus.dout), 32'h2);
        bus.tap = 4'd8;
        cyc();
        chk("rd_oor_err", 32'(bus.err), 32'h1);
        chk("rd_oor_dout", 32'(bus.dout), 32'h0);
        chk("rd_oor_valid", 32'(bus.dout_valid), 32'h1);
        bus.tap = 4'd15;
        cyc();
        chk("rd_oor15_err", 32'(bus.err), 32'h1);
        bus.rd = 1'b0;
        cyc();
        chk("idle_valid", 32'(bus.dout_valid), 32'h0);
        chk("idle_err", 32'(bus.err), 32'h0);

        // Burst: 9,8,...,2 newest first; a write mid-burst is dropped.
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        chk("b_word0", 32'(bus.dout), 32'h9);
        chk("b_busy0", 32'(bus.busy), 32'h1);
        chk("b_valid0", 32'(bus.dout_valid), 32'h1);
        for (int k = 1; k < 8; k++) begin
            if (k == 3) begin
                bus.we    = 1'b1;
                bus.din   = 24'hAAAAAA;
                bus.rd    = 1'b1;
                bus.tap   = 4'd8;
                bus.start = 1'b1;
            end
            cyc();
            bus.we    = 1'b0;
            bus.rd    = 1'b0;
            bus.start = 1'b0;
            chk("b_word", 32'(bus.dout), 32'(9 - k));
            chk("b_valid", 32'(bus.dout_valid), 32'h1);
            chk("b_busy", 32'(bus.busy), 32'h1);
            chk("b_err", 32'(bus.err), 32'h0);
        end
        chk("b_lost", 32'(bus.lost), 32'h1);
        cyc();
        chk("b_done", 32'(bus.done), 32'h1);
        chk("b_done_busy", 32'(bus.busy), 32'h0);
        chk("b_done_valid", 32'(bus.dout_valid), 32'h0);
        cyc();
        chk("b_done_pulse", 32'(bus.done), 32'h0);
        chk("b_fill", 32'(bus.fill), 32'h8);

        bus.rd  = 1'b1;
        bus.tap = 4'd0;
        cyc();
        bus.rd = 1'b0;
        chk("no_shift", 32'(bus.dout), 32'h9);
        chk("lost_sticky", 32'(bus.lost), 32'h1);

        // start & we together: burst streams post-write contents, lost clears.
        bus.start = 1'b1;
        bus.we    = 1'b1;
        bus.din   = 24'h00BEEF;
        cyc();
        bus.start = 1'b0;
        bus.we    = 1'b0;
        chk("sw_word0", 32'(bus.dout), 32'h00BEEF);
        chk("sw_lost_clr", 32'(bus.lost), 32'h0);
        chk("sw_busy", 32'(bus.busy), 32'h1);
        cyc();
        chk("sw_word1", 32'(bus.dout), 32'h9);
        cyc();
        chk("sw_word2", 32'(bus.dout), 32'h8);

        bus.en = 1'b0;
        for (int g = 0; g < 3; g++) begin
            cyc();
            chk("gap_valid", 32'(bus.dout_valid), 32'h0);
            chk("gap_hold", 32'(bus.dout), 32'h8);
            chk("gap_busy", 32'(bus.busy), 32'h1);
        end
        bus.en = 1'b1;
        cyc();
        chk("gap_word3", 32'(bus.dout), 32'h7);
        chk("gap_valid3", 32'(bus.dout_valid), 32'h1);
        cyc();
        chk("gap_word4", 32'(bus.dout), 32'h6);

        // Asynchronous reset mid-burst.
        #3;
        rstn = 1'b0;
        #1;
        chk("ar_busy", 32'(bus.busy), 32'h0);
        chk("ar_dout", 32'(bus.dout), 32'h0);
        chk("ar_valid", 32'(bus.dout_valid), 32'h0);
        chk("ar_fill", 32'(bus.fill), 32'h0);
        cyc();
        rstn = 1'b1;
        for (int d = 0; d < 3; d++) begin
            cyc();
            chk("ar_no_done", 32'(bus.done), 32'h0);
            chk("ar_idle_busy", 32'(bus.busy), 32'h0);
        end
        bus.rd  = 1'b1;
        bus.tap = 4'd5;
        cyc();
        bus.rd = 1'b0;
        chk("ar_tap_rstval", 32'(bus.dout), 32'(RV));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
